// File: rtl/intr_pkg.sv
// Shared constants and one-hot state encodings for the CPU-side interrupt agent.
package intr_pkg;
  localparam int NUM_INTR_DEF = 16;
  localparam int TIMEOUT_DEF  = 16;
  localparam int IDX_W        = $clog2(NUM_INTR_DEF);

  typedef enum logic [2:0] {
    CFG_IDLE   = 3'b001,
    CFG_ACCESS = 3'b010,
    CFG_DONE   = 3'b100
  } cfg_state_e;

  typedef enum logic [4:0] {
    SVC_IDLE   = 5'b00001,
    SVC_PEND   = 5'b00010,
    SVC_ACTIVE = 5'b00100,
    SVC_RETIRE = 5'b01000,
    SVC_DRAIN  = 5'b10000
  } svc_state_e;
endpackage

// File: rtl/intr_apb_master.sv
// Config-side bus master: one access per request, ack 1 cycle after pready (or timeout).
// Requests arriving while busy are dropped; bad indices ack next cycle with no bus access.
module intr_apb_master
  import intr_pkg::*;
#(
  parameter int NUM_INTR = NUM_INTR_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_i,
  input  logic       write_i,
  input  logic [7:0] idx_i,
  input  logic [7:0] wdata_i,
  output logic       ack_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  output logic [7:0] paddr_o,
  output logic [7:0] pwdata_o,
  output logic       pwrite_o,
  output logic       penable_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  cfg_state_e       state_q;
  logic [CNT_W-1:0] tmo_q;
  logic             ack_q, err_q, pwrite_q, penable_q;
  logic [7:0]       rdata_q, paddr_q, pwdata_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= CFG_IDLE;
      tmo_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        CFG_IDLE: begin
          if (req_i) begin
            if (int'(idx_i) >= NUM_INTR) begin
              state_q <= CFG_DONE;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q   <= CFG_ACCESS;
              penable_q <= 1'b1;
              paddr_q   <= idx_i;
              pwdata_q  <= wdata_i;
              pwrite_q  <= write_i;
              tmo_q     <= '0;
            end
          end
        end
        CFG_ACCESS: begin
          // A late pready wins over the timeout on the same edge.
          if (pready_i) begin
            state_q   <= CFG_DONE;
            penable_q <= 1'b0;
            ack_q     <= 1'b1;
            if (!pwrite_q) rdata_q <= prdata_i;
          end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
            state_q   <= CFG_DONE;
            penable_q <= 1'b0;
            ack_q     <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        CFG_DONE: state_q <= CFG_IDLE;
        default:  state_q <= CFG_IDLE;
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign penable_o = penable_q;
endmodule

// File: rtl/intr_cpu_agent.sv
// CPU-side interrupt agent: config master plus IRQ service tracking (IRQ 1 cycle after offer,
// serviced pulse 1 cycle after done); offers are only taken when idle and enabled.
module intr_cpu_agent
  import intr_pkg::*;
#(
  parameter int NUM_INTR = NUM_INTR_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             pclk_i,
  input  logic             prst_n_i,
  output logic [7:0]       paddr_o,
  output logic [7:0]       pwdata_o,
  input  logic [7:0]       prdata_i,
  output logic             pwrite_o,
  output logic             penable_o,
  input  logic             pready_i,
  input  logic             cfg_req_i,
  input  logic             cfg_write_i,
  input  logic [7:0]       cfg_idx_i,
  input  logic [7:0]       cfg_wdata_i,
  output logic             cfg_ack_o,
  output logic [7:0]       cfg_rdata_o,
  output logic             cfg_err_o,
  input  logic             intr_valid_i,
  input  logic [IDX_W-1:0] intr_to_service_i,
  output logic             intr_serviced_o,
  input  logic             irq_en_i,
  output logic             irq_o,
  output logic [IDX_W-1:0] irq_id_o,
  input  logic             irq_ack_i,
  input  logic             irq_done_i,
  output logic [15:0]      serviced_cnt_o
);
  svc_state_e       svc_q;
  logic             irq_q, serviced_q;
  logic [IDX_W-1:0] irq_id_q;
  logic [15:0]      cnt_q;

  intr_apb_master #(.NUM_INTR(NUM_INTR), .TIMEOUT(TIMEOUT)) u_apb (
    .clk_i     (pclk_i),
    .rst_n_i   (prst_n_i),
    .req_i     (cfg_req_i),
    .write_i   (cfg_write_i),
    .idx_i     (cfg_idx_i),
    .wdata_i   (cfg_wdata_i),
    .ack_o     (cfg_ack_o),
    .err_o     (cfg_err_o),
    .rdata_o   (cfg_rdata_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .pwrite_o  (pwrite_o),
    .penable_o (penable_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i)
  );

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      svc_q      <= SVC_IDLE;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      serviced_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      serviced_q <= 1'b0;
      unique case (svc_q)
        SVC_IDLE: begin
          if (intr_valid_i && irq_en_i) begin
            svc_q    <= SVC_PEND;
            irq_q    <= 1'b1;
            irq_id_q <= intr_to_service_i;
          end
        end
        SVC_PEND: begin
          if (irq_ack_i) begin
            irq_q <= 1'b0;
            if (irq_done_i) begin
              svc_q      <= SVC_RETIRE;
              serviced_q <= 1'b1;
              cnt_q      <= cnt_q + 16'd1;
            end else begin
              svc_q <= SVC_ACTIVE;
            end
          end
        end
        SVC_ACTIVE: begin
          if (irq_done_i) begin
            svc_q      <= SVC_RETIRE;
            serviced_q <= 1'b1;
            cnt_q      <= cnt_q + 16'd1;
          end
        end
        SVC_RETIRE: svc_q <= SVC_DRAIN;
        // Hold off until the controller withdraws the offer we just serviced.
        SVC_DRAIN:  if (!intr_valid_i) svc_q <= SVC_IDLE;
        default:    svc_q <= SVC_IDLE;
      endcase
    end
  end

  assign irq_o           = irq_q;
  assign irq_id_o        = irq_id_q;
  assign intr_serviced_o = serviced_q;
  assign serviced_cnt_o  = cnt_q;
endmodule

// File: tb/tb_intr_cpu_agent.sv
// Bench for intr_cpu_agent: table-driven config accesses against a small controller model,
// random config/service traffic against a reference model, and hand-written corner sequences.
module tb_intr_cpu_agent;
  logic       pclk = 1'b0;
  logic       prst_n;
  logic [7:0] paddr_o, pwdata_o, prdata;
  logic       pwrite_o, penable_o, pready;
  logic       cfg_req, cfg_write;
  logic [7:0] cfg_idx, cfg_wdata;
  logic       cfg_ack_o, cfg_err_o;
  logic [7:0] cfg_rdata_o;
  logic       intr_valid, irq_en, irq_ack, irq_done;
  logic [3:0] intr_tos;
  logic       intr_serviced_o, irq_o;
  logic [3:0] irq_id_o;
  logic [15:0] serviced_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  logic       stall = 1'b0;
  logic       pen_prev = 1'b0;
  logic [7:0] sregs [256];
  logic [7:0] mreg [256];

  typedef struct {
    logic       w;
    logic [7:0] idx;
    logic [7:0] wd;
    logic       st;
    int         lat;
    logic       err;
    logic [7:0] rd;
    int         pen;
  } vec_t;
  vec_t tbl [10];

  intr_cpu_agent #(.NUM_INTR(16), .TIMEOUT(16)) dut (
    .pclk_i            (pclk),
    .prst_n_i          (prst_n),
    .paddr_o           (paddr_o),
    .pwdata_o          (pwdata_o),
    .prdata_i          (prdata),
    .pwrite_o          (pwrite_o),
    .penable_o         (penable_o),
    .pready_i          (pready),
    .cfg_req_i         (cfg_req),
    .cfg_write_i       (cfg_write),
    .cfg_idx_i         (cfg_idx),
    .cfg_wdata_i       (cfg_wdata),
    .cfg_ack_o         (cfg_ack_o),
    .cfg_rdata_o       (cfg_rdata_o),
    .cfg_err_o         (cfg_err_o),
    .intr_valid_i      (intr_valid),
    .intr_to_service_i (intr_tos),
    .intr_serviced_o   (intr_serviced_o),
    .irq_en_i          (irq_en),
    .irq_o             (irq_o),
    .irq_id_o          (irq_id_o),
    .irq_ack_i         (irq_ack),
    .irq_done_i        (irq_done),
    .serviced_cnt_o    (serviced_cnt_o)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock, then the controller model answers: pready one cycle after penable rises.
  task automatic tick();
    @(posedge pclk);
    #1;
    if (stall || !penable_o) begin
      pready = 1'b0;
    end else if (pen_prev && !pready) begin
      pready = 1'b1;
      prdata = sregs[paddr_o];
      if (pwrite_o) sregs[paddr_o] = pwdata_o;
    end else begin
      pready = 1'b0;
    end
    pen_prev = penable_o;
  endtask

  task automatic cfg_op(input logic w, input logic [7:0] idx, input logic [7:0] wd, input logic st,
                        output int lat, output logic err, output logic [7:0] rd, output int pen);
    stall = st;
    cfg_req = 1'b1; cfg_write = w; cfg_idx = idx; cfg_wdata = wd;
    lat = 0; pen = 0; err = 1'b0; rd = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      tick();
      cfg_req = 1'b0;
      if (penable_o) pen++;
      if (cfg_ack_o) begin
        lat = i; err = cfg_err_o; rd = cfg_rdata_o;
        break;
      end
    end
    if (lat == 0) begin
      n_vec++; n_err++;
      $display("FAIL cfg_ack_wait: no ack within 40 cycles for idx %0d", idx);
    end
    tick();
    chk("cfg_ack_single", {31'd0, cfg_ack_o}, 32'd0);
    chk("cfg_pen_gap", {31'd0, penable_o}, 32'd0);
    stall = 1'b0;
  endtask

  initial begin
    int         lat, pen, e_lat, e_pen;
    logic       err, e_err, ok_idx;
    logic [7:0] rd, m_rd;
    logic       m_pend, m_act, m_ret, m_drn;
    logic [3:0] m_id;
    int         m_cnt;
    logic       s_valid, s_en, s_ack, s_done;
    logic [3:0] s_tos;

    for (int i = 0; i < 256; i++) begin sregs[i] = 8'h00; mreg[i] = 8'h00; end
    cfg_req = 0; cfg_write = 0; cfg_idx = 0; cfg_wdata = 0; pready = 0; prdata = 0;
    intr_valid = 0; intr_tos = 0; irq_en = 0; irq_ack = 0; irq_done = 0;
    prst_n = 1'b1;
    #3 prst_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_penable", {31'd0, penable_o}, 0);
    chk("rst_cfg_ack", {31'd0, cfg_ack_o}, 0);
    chk("rst_cfg_err", {31'd0, cfg_err_o}, 0);
    chk("rst_cfg_rdata", {24'd0, cfg_rdata_o}, 0);
    chk("rst_paddr", {24'd0, paddr_o}, 0);
    chk("rst_pwdata", {24'd0, pwdata_o}, 0);
    chk("rst_pwrite", {31'd0, pwrite_o}, 0);
    chk("rst_irq", {31'd0, irq_o}, 0);
    chk("rst_irq_id", {28'd0, irq_id_o}, 0);
    chk("rst_serviced", {31'd0, intr_serviced_o}, 0);
    chk("rst_cnt", {16'd0, serviced_cnt_o}, 0);
    prst_n = 1'b1;
    tick();

    tbl[0] = '{1'b1, 8'd3,   8'h0A, 1'b0, 3,  1'b0, 8'h00, 2};
    tbl[1] = '{1'b0, 8'd3,   8'h00, 1'b0, 3,  1'b0, 8'h0A, 2};
    tbl[2] = '{1'b1, 8'd16,  8'h33, 1'b0, 1,  1'b1, 8'h0A, 0};
    tbl[3] = '{1'b1, 8'd15,  8'h5C, 1'b0, 3,  1'b0, 8'h0A, 2};
    tbl[4] = '{1'b0, 8'd15,  8'h00, 1'b0, 3,  1'b0, 8'h5C, 2};
    tbl[5] = '{1'b0, 8'd255, 8'h00, 1'b0, 1,  1'b1, 8'h5C, 0};
    tbl[6] = '{1'b1, 8'd2,   8'h77, 1'b1, 17, 1'b1, 8'h5C, 16};
    tbl[7] = '{1'b0, 8'd2,   8'h00, 1'b0, 3,  1'b0, 8'h00, 2};
    tbl[8] = '{1'b0, 8'd3,   8'h00, 1'b1, 17, 1'b1, 8'h00, 16};
    tbl[9] = '{1'b0, 8'd3,   8'h00, 1'b0, 3,  1'b0, 8'h0A, 2};
    for (int i = 0; i < 10; i++) begin
      cfg_op(tbl[i].w, tbl[i].idx, tbl[i].wd, tbl[i].st, lat, err, rd, pen);
      chk("tbl_latency", lat, tbl[i].lat);
      chk("tbl_err", {31'd0, err}, {31'd0, tbl[i].err});
      chk("tbl_rdata", {24'd0, rd}, {24'd0, tbl[i].rd});
      chk("tbl_pen_cycles", pen, tbl[i].pen);
    end

    // Random config traffic: register contents tracked as plain last-write-wins memory.
    mreg[3] = 8'h0A; mreg[15] = 8'h5C; m_rd = 8'h0A;
    for (int i = 0; i < 30; i++) begin
      logic       w, st;
      logic [7:0] idx, wd;
      w = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0);
      idx = 8'($urandom_range(0, 20));
      wd = 8'($urandom);
      ok_idx = (idx < 8'd16);
      e_lat = !ok_idx ? 1 : (st ? 17 : 3);
      e_pen = !ok_idx ? 0 : (st ? 16 : 2);
      e_err = !ok_idx || st;
      if (ok_idx && !st) begin
        if (w) mreg[idx] = wd;
        else   m_rd = mreg[idx];
      end
      cfg_op(w, idx, wd, st, lat, err, rd, pen);
      chk("rnd_cfg_latency", lat, e_lat);
      chk("rnd_cfg_err", {31'd0, err}, {31'd0, e_err});
      chk("rnd_cfg_rdata", {24'd0, rd}, {24'd0, m_rd});
      chk("rnd_cfg_pen", pen, e_pen);
    end

    // Line 5 offered; core acks 2 cycles later, done 4 after that; en drops mid-service.
    intr_valid = 1; intr_tos = 4'd5; irq_en = 1;
    tick();
    chk("a_irq_rise", {31'd0, irq_o}, 1);
    chk("a_irq_id", {28'd0, irq_id_o}, 5);
    tick();
    chk("a_irq_held", {31'd0, irq_o}, 1);
    irq_ack = 1;
    tick();
    irq_ack = 0; irq_en = 0;
    chk("a_irq_fall", {31'd0, irq_o}, 0);
    tick(); tick(); tick();
    irq_en = 1; irq_done = 1;
    tick();
    irq_done = 0; intr_tos = 4'd7;
    chk("a_serviced", {31'd0, intr_serviced_o}, 1);
    chk("a_cnt", {16'd0, serviced_cnt_o}, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_no_retake_irq", {31'd0, irq_o}, 0);
      chk("a_single_pulse", {31'd0, intr_serviced_o}, 0);
    end
    chk("a_id_kept", {28'd0, irq_id_o}, 5);
    intr_valid = 0;
    tick(); tick();

    // Ack and done together while pending go straight to retire.
    intr_valid = 1; intr_tos = 4'd9;
    tick();
    chk("b_irq", {31'd0, irq_o}, 1);
    irq_ack = 1; irq_done = 1;
    tick();
    irq_ack = 0; irq_done = 0; intr_valid = 0;
    chk("b_serviced", {31'd0, intr_serviced_o}, 1);
    chk("b_irq_low", {31'd0, irq_o}, 0);
    chk("b_cnt", {16'd0, serviced_cnt_o}, 2);
    tick(); tick();

    // Random service traffic against a phase model built from the service rules.
    m_pend = 0; m_act = 0; m_ret = 0; m_drn = 0; m_id = 4'd9; m_cnt = 2;
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_tos   = 4'($urandom_range(0, 15));
      s_en    = ($urandom_range(0, 3) != 0);
      s_ack   = ($urandom_range(0, 2) == 0);
      s_done  = ($urandom_range(0, 2) == 0);
      intr_valid = s_valid; intr_tos = s_tos; irq_en = s_en; irq_ack = s_ack; irq_done = s_done;
      tick();
      if (m_ret) begin
        m_ret = 0; m_drn = 1;
      end else if (m_drn) begin
        if (!s_valid) m_drn = 0;
      end else if (m_pend) begin
        if (s_ack) begin
          m_pend = 0;
          if (s_done) begin m_ret = 1; m_cnt = (m_cnt + 1) % 65536; end
          else m_act = 1;
        end
      end else if (m_act) begin
        if (s_done) begin m_act = 0; m_ret = 1; m_cnt = (m_cnt + 1) % 65536; end
      end else if (s_valid && s_en) begin
        m_pend = 1; m_id = s_tos;
      end
      chk("rnd_irq", {31'd0, irq_o}, {31'd0, m_pend});
      chk("rnd_serviced", {31'd0, intr_serviced_o}, {31'd0, m_ret});
      chk("rnd_irq_id", {28'd0, irq_id_o}, {28'd0, m_id});
      chk("rnd_cnt", {16'd0, serviced_cnt_o}, m_cnt);
    end

    // Bring the service path back to idle, then reset mid-service and mid-access.
    intr_valid = 0; irq_ack = 1; irq_done = 1; irq_en = 1;
    repeat (4) tick();
    irq_ack = 0; irq_done = 0;
    intr_valid = 1; intr_tos = 4'd3;
    tick();
    irq_ack = 1;
    tick();
    irq_ack = 0;
    stall = 1; cfg_req = 1; cfg_write = 1; cfg_idx = 8'd4; cfg_wdata = 8'hEE;
    tick();
    cfg_req = 0;
    tick();
    chk("c_pen_before", {31'd0, penable_o}, 1);
    prst_n = 1'b0;
    #1;
    chk("c_rst_penable", {31'd0, penable_o}, 0);
    chk("c_rst_irq", {31'd0, irq_o}, 0);
    chk("c_rst_serviced", {31'd0, intr_serviced_o}, 0);
    chk("c_rst_cnt", {16'd0, serviced_cnt_o}, 0);
    chk("c_rst_irq_id", {28'd0, irq_id_o}, 0);
    chk("c_rst_paddr", {24'd0, paddr_o}, 0);
    stall = 0; pen_prev = 0; intr_valid = 0;
    tick();
    prst_n = 1'b1;
    tick();
    chk("c_idle_after", {31'd0, irq_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/intr_cpu_agent.md
# intr_cpu_agent

Processor-side counterpart of the interrupt controller. It programs and reads back the controller's per-line priority registers through a simple APB-style master. It also takes the controller's `intr_valid`/`intr_to_service` offer, presents it to the core as an IRQ, tracks acknowledge and handler completion, and returns the one-cycle `intr_serviced` pulse. It sits between the CPU core and the interrupt controller.

## Interface
- `NUM_INTR`, 16: number of interrupt lines; legal priority index range is 0..NUM_INTR-1.
- `TIMEOUT`, 16: cycles `penable_o` may stay high without `pready_i` before the access is aborted.
- `pclk_i` input 1: single clock, rising edge.
- `prst_n_i` input 1: reset is asynchronous and active-low.
- `paddr_o` output 8: priority register index.
- `pwdata_o` output 8: write data.
- `prdata_i` input 8: read data; valid while `pready_i`=1.
- `pwrite_o` output 1: 1 = write, 0 = read.
- `penable_o` output 1: access strobe (no select line).
- `pready_i` input 1: access complete.
- `cfg_req_i` input 1: config request, one-cycle pulse.
- `cfg_write_i` input 1: request type.
- `cfg_idx_i` input 8: register index.
- `cfg_wdata_i` input 8: write data.
- `cfg_ack_o` output 1: one-cycle completion pulse.
- `cfg_rdata_o` output 8: read result; holds until the next ack.
- `cfg_err_o` output 1: qualifies `cfg_ack_o`; 1 = bad index or timeout.
- `intr_valid_i` input 1: controller offers an interrupt.
- `intr_to_service_i` input 4: offered line.
- `intr_serviced_o` output 1: one-cycle serviced pulse back to the controller.
- `irq_en_i` input 1: global enable; when 0, no new offer is taken.
- `irq_o` output 1: IRQ to the core.
- `irq_id_o` output 4: latched line number.
- `irq_ack_i` input 1: core has taken the IRQ.
- `irq_done_i` input 1: handler finished.
- `serviced_cnt_o` output 16: count of completed services; wraps.

## Operation
- Reset value of every output is 0; both FSMs are in IDLE and `cfg_rdata_o` is 0.
- Config FSM (IDLE, ACCESS, DONE):
  - In IDLE, `cfg_req_i`=1 with `cfg_idx_i` >= NUM_INTR goes straight to DONE with `cfg_err_o`=1; no bus access is made.
  - Otherwise the request fields are latched and the FSM enters ACCESS.
  - ACCESS drives `penable_o`=1 with `paddr_o`/`pwrite_o`/`pwdata_o` held stable. On `pready_i`=1 it captures `prdata_i` (reads only) and moves to DONE.
  - If the ACCESS cycle counter reaches TIMEOUT, the FSM moves to DONE with `cfg_err_o`=1.
  - DONE: `penable_o`=0, `cfg_ack_o`=1 for one cycle, then IDLE. `penable_o` is therefore low for at least one cycle between accesses.
  - `cfg_req_i` outside IDLE is ignored; no queueing.
- Service FSM (IDLE, PEND, ACTIVE, RETIRE, DRAIN):
  - IDLE → PEND when `intr_valid_i`=1 and `irq_en_i`=1; `irq_id_o` latches `intr_to_service_i`.
  - PEND: `irq_o`=1. `irq_ack_i` → ACTIVE. `irq_ack_i` and `irq_done_i` together → RETIRE.
  - ACTIVE: `irq_o`=0. `irq_done_i` → RETIRE.
  - RETIRE: `intr_serviced_o`=1 for one cycle, `serviced_cnt_o`+1 (wraps 0xFFFF→0), then DRAIN.
  - DRAIN: wait until `intr_valid_i`=0 is sampled, then IDLE. This prevents re-taking a stale offer.
  - `irq_en_i` dropping in PEND/ACTIVE does not abort the current service.
- The two FSMs are independent; config traffic may overlap a service.
- Asserting `prst_n_i` mid-access or mid-service aborts immediately. `penable_o`, `irq_o` and `intr_serviced_o` go low asynchronously.

## Timing
- Config access latency: request at edge N → `penable_o` high from N+1; `pready_i` seen at edge M → `cfg_ack_o` at M+1.
- Against the controller (pready 1 cycle after penable), a valid access completes in 3 cycles request-to-ack. A bad index acks in 1 cycle.
- Service path:
  - `intr_valid_i` sampled high → `irq_o` the next cycle.
  - `irq_done_i` sampled → `intr_serviced_o` the next cycle.
  - The controller drops valid one cycle later; the earliest re-entry to PEND is 2 cycles after DRAIN exits.
- All outputs are registered.

## Structure
- Package `intr_pkg`: NUM_INTR, TIMEOUT default, config and service state encodings (one-hot, matching the controller's style), index width constant.
- Sub-module `intr_apb_master`: ACCESS/DONE sequencing, timeout counter, read capture. The top holds the service FSM and counter.

## Test plan
- Write idx 3 = 0x0A, then read idx 3 → `cfg_ack_o` with `cfg_rdata_o`=0x0A, `cfg_err_o`=0, 3 cycles each.
- `cfg_idx_i`=16 → `cfg_ack_o`+`cfg_err_o` next cycle, `penable_o` never high.
- Hold `pready_i`=0 → ack with `cfg_err_o`=1 after TIMEOUT=16 cycles, then `penable_o`=0.
- Controller offers line 5; core acks 2 cycles later, done 4 later → `irq_id_o`=5, single `intr_serviced_o` pulse, `serviced_cnt_o`=1, no re-take before valid drops.
- `irq_ack_i` and `irq_done_i` in the same cycle in PEND, and `prst_n_i` low during ACTIVE → direct RETIRE in the first case; all outputs 0 immediately in the second.
